// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The FUNCT3_* codes are the common RISC-V load/store encodings.
package dmem_arbiter_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // Arbiter sequencing: one IDLE cycle to accept, one ACCESS cycle on the memory port.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Request fields captured at handshake.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  funct3;
  } req_t;

  // Access width in bytes implied by funct3 (low two bits select B/H/W).
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    logic [2:0] nbytes;
    case (funct3[1:0])
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    return nbytes;
  endfunction

  // Only the standard load/store encodings are accepted.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    if (we) begin
      case (funct3)
        FUNCT3_SB, FUNCT3_SH, FUNCT3_SW: legal = 1'b1;
        default:                         legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        FUNCT3_LB, FUNCT3_LH, FUNCT3_LW,
        FUNCT3_LBU, FUNCT3_LHU:          legal = 1'b1;
        default:                         legal = 1'b0;
      endcase
    end
    return legal;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two packed valid/ready
// request channels plus a shared registered response.
interface dmem_arbiter_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_we;
  logic [5:0]  req_funct3;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Requesters (core load/store path, debug/DMA port).
  modport master (
    output req_valid, req_addr, req_wdata, req_we, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Arbiter.
  modport slave (
    input  req_valid, req_addr, req_wdata, req_we, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_access_check.sv
// Combinational legality check for one data-memory access:
// alignment, address range relative to BASE_ADDR, and funct3 encoding.
module dmem_access_check
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h00010000
) (
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic        we,
  output logic        err
);

  // One extra bit so the end-of-access sum never wraps.
  localparam logic [32:0] MEM_BYTES = 33'(MEM_SIZE) * 33'd4;

  logic [2:0]  nbytes;
  logic        legal;
  logic        misaligned;
  logic        below;
  logic        above;
  logic [32:0] end_off;

  // Classify the access; any single failure flags it as an error.
  always_comb begin
    nbytes     = access_bytes(funct3);
    legal      = funct3_legal(we, funct3);
    misaligned = ((nbytes == 3'd2) && addr[0]) ||
                 ((nbytes == 3'd4) && (addr[1:0] != 2'b00));
    below      = (addr < BASE_ADDR);
    end_off    = {1'b0, addr - BASE_ADDR} + 33'(nbytes);
    above      = (end_off > MEM_BYTES);
    err        = !legal || misaligned || below || above;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and single-port sequencer for
// data_memory. Each accepted request occupies the memory port for exactly
// one ACCESS cycle; the response is registered and pulses the cycle after.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h00010000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_arbiter_if.slave        bus,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [2:0]           mem_funct3,
  input  logic [31:0]          mem_rdata
);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  req_t        req_q, req_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        sel;
  logic [1:0]  ready;
  logic        err;
  logic        do_read;
  logic        do_write;
  req_t        req_sel;

  // Error is derived from the latched request, so it is stable through ACCESS.
  dmem_access_check #(
    .MEM_SIZE  (MEM_SIZE),
    .BASE_ADDR (BASE_ADDR)
  ) u_check (
    .addr   (req_q.addr),
    .funct3 (req_q.funct3),
    .we     (req_q.we),
    .err    (err)
  );

  // Requester selection: sole requester wins, conflicts go to the one not granted last.
  always_comb begin
    sel = 1'b0;
    case (bus.req_valid)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_grant_q;
      default: sel = 1'b0;
    endcase
    ready = '0;
    if ((state_q == ST_IDLE) && (|bus.req_valid)) begin
      ready = sel ? 2'b10 : 2'b01;
    end
    req_sel.addr   = sel ? bus.req_addr[63:32]  : bus.req_addr[31:0];
    req_sel.wdata  = sel ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
    req_sel.we     = sel ? bus.req_we[1]        : bus.req_we[0];
    req_sel.funct3 = sel ? bus.req_funct3[5:3]  : bus.req_funct3[2:0];
  end

  // Next-state, memory strobes and response generation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    req_d        = req_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    do_read      = 1'b0;
    do_write     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|ready) begin
          req_d        = req_sel;
          gnt_d        = sel;
          last_grant_d = sel;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        do_read     = ~req_q.we & ~err;
        do_write    = req_q.we & ~err;
        rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
        rsp_rdata_d = do_read ? mem_rdata : '0;
        rsp_err_d   = err;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched request; async reset also kills an in-flight store strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      req_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      req_q        <= req_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign mem_addr   = req_q.addr;
  assign mem_wdata  = req_q.wdata;
  assign mem_funct3 = req_q.funct3;
  assign mem_read   = do_read;
  assign mem_write  = do_write;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and access sequencer in front of data_memory.
- Requester 0 is the core load/store path; requester 1 is the debug/DMA port.
- Accepts valid/ready requests, checks alignment and range, and drives data_memory's single port for exactly one cycle per access.
- Returns a registered response (read data or error) to the requester that was granted.

Parameters:
MEM_SIZE, 16384, data_memory size in words; legal byte range is 0..MEM_SIZE*4-1 relative to BASE_ADDR
BASE_ADDR, 32'h00010000, base byte address of data memory

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-requester request valid, bit i = requester i
req_ready  output  2  per-requester accept; combinational, one-hot or zero
req_addr  input  64  packed byte addresses, [32i+31:32i] = requester i
req_wdata  input  64  packed store data
req_we  input  2  1 = store, 0 = load
req_funct3  input  6  packed RISC-V load/store funct3, [3i+2:3i]
rsp_valid  output  2  one-cycle response pulse, bit i = requester i
rsp_rdata  output  32  load result, shared by both requesters; qualified by rsp_valid
rsp_err  output  1  error flag for the current response; qualified by rsp_valid
mem_addr  output  32  to data_memory addr
mem_wdata  output  32  to data_memory write_data
mem_read  output  1  to data_memory mem_read
mem_write  output  1  to data_memory mem_write
mem_funct3  output  3  to data_memory funct3
mem_rdata  input  32  from data_memory read_data (combinational)

Behaviour:
- Reset values:
  - FSM = IDLE, last_grant = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - All mem_* outputs are 0 (they are driven from latched registers that reset to 0).
- FSM states: IDLE, ACCESS.
- IDLE:
  - req_ready[i] = 1 for the selected requester only.
  - If only one requester has req_valid set, that requester is selected.
  - If both are valid, the requester that is not last_grant is selected (round-robin). Requester 0 therefore wins the first conflict after reset.
  - On handshake (valid & ready), latch addr, wdata, we, funct3 and the grant ID; update last_grant; go to ACCESS.
- ACCESS (exactly one cycle):
  - Drive mem_addr, mem_wdata and mem_funct3 from the latched request.
  - mem_read = ~we & ~err; mem_write = we & ~err.
  - A store commits at the clock edge that ends ACCESS.
  - For loads, mem_rdata is captured into rsp_rdata at that same edge.
  - Always return to IDLE.
  - req_ready = 0 in this state.
- Response:
  - rsp_valid[grant] = 1 for exactly the cycle after ACCESS.
  - rsp_rdata = captured mem_rdata for a good load; 0 for stores and for errors.
  - rsp_err = err.
- Throughput and latency:
  - A new request may be accepted in the same cycle a response is presented, giving 2-cycle throughput.
  - Latency from handshake edge to rsp_valid is 2 cycles.
- Outside ACCESS: mem_read = mem_write = 0; mem_addr, mem_wdata and mem_funct3 hold their last latched values.
- err is computed combinationally from the latched request:
  - Misaligned: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - Out of range: addr < BASE_ADDR, or addr - BASE_ADDR > MEM_SIZE*4 - access_bytes.
  - Illegal funct3: any funct3 other than LB/LH/LW/LBU/LHU for loads or SB/SH/SW for stores.
  - An erroring access never asserts mem_read or mem_write.
- Address arithmetic is 32-bit unsigned with no wrap. An access whose last byte lies above the top of memory is out of range.
- Requesters must hold their request fields stable while valid is set and ready is low. The arbiter does not check this.
- Asynchronous reset in ACCESS:
  - mem_write drops immediately and the store is not committed.
  - No response is issued after reset.

Decomposition:
- Shared riscv_defs.v holds the FUNCT3_* load/store codes; reuse them, add no new ones.
- Local constants: the 1-bit state encodings for IDLE and ACCESS.
- One natural sub-module, dmem_access_check: purely combinational; inputs addr, funct3, we; output err. Unit-testable on its own.

Test Plan:
1. Requester 0 SW addr 0x00010000 data 0xDEADBEEF, then LW same addr -> second response rsp_rdata = 0xDEADBEEF, rsp_err = 0, 2 cycles after each handshake.
2. Both requesters valid in the same cycle, held for 4 requests -> grant order 0, 1, 0, 1; one-hot req_ready; no cycle with both mem_read and mem_write set.
3. Requester 1 LH at 0x00010001 -> rsp_err = 1, rsp_rdata = 0, mem_read never asserted.
4. SW at 0x0001FFFC -> OK; SW at 0x0001FFFD -> err; LB at 0x00020000 -> err; LB at 0x0000FFFF -> err.
5. SB 0x80 at 0x00010004; LB -> 0xFFFFFF80; LBU -> 0x00000080.
6. rst_n pulsed low during the ACCESS of SW 0x12345678 to 0x00010008 -> later LW returns the prior value (0), and rsp_valid stays 0 through reset.
